// File: rtl/vp_lvp_table.sv
// Last-value prediction table: N-lane lookup of predicted results with
// saturating confidence, trained from writeback feedback, with a flush sweep.
module vp_lvp_table #(
  parameter int unsigned NUM_LANES   = 2,
  parameter int unsigned ENTRIES     = 64,
  parameter int unsigned TAG_W       = 8,
  parameter int unsigned CONF_W      = 3,
  parameter int unsigned CONF_THRESH = 7
) (
  input  logic                        clk,
  input  logic                        rst_l,
  input  logic [NUM_LANES-1:0]        lk_valid,
  input  logic [NUM_LANES*31-1:0]     lk_pc,
  output logic [NUM_LANES-1:0]        pred_valid,
  output logic [NUM_LANES*32-1:0]     pred_value,
  output logic [NUM_LANES*CONF_W-1:0] pred_conf,
  output logic [NUM_LANES-1:0]        pred_use,
  input  logic                        fb_valid,
  input  logic [30:0]                 fb_pc,
  input  logic [31:0]                 fb_actual,
  input  logic                        fb_used,
  output logic                        fb_misp,
  input  logic                        flush_req,
  output logic                        busy
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned PC_W  = 31;
  localparam int unsigned VAL_W = 32;
  localparam logic [CONF_W-1:0] CONF_MAX = '1;
  localparam logic [CONF_W-1:0] THRESH   = CONF_W'(CONF_THRESH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ENTRIES - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic [ENTRIES-1:0] v_q;
  logic [TAG_W-1:0]   tag_mem  [ENTRIES];
  logic [VAL_W-1:0]   val_mem  [ENTRIES];
  logic [CONF_W-1:0]  conf_mem [ENTRIES];

  logic [IDX_W-1:0]   lk_idx [NUM_LANES];
  logic [TAG_W-1:0]   lk_tag [NUM_LANES];
  logic [NUM_LANES-1:0]        hit_d, use_d;
  logic [NUM_LANES*VAL_W-1:0]  value_d;
  logic [NUM_LANES*CONF_W-1:0] conf_d;

  logic [IDX_W-1:0]   fb_idx;
  logic [TAG_W-1:0]   fb_tag;
  logic               fb_hit, fb_match, train, misp_d;
  logic [CONF_W-1:0]  conf_new;

  // Upper PC bits beyond index and tag are intentionally ignored.
  logic unused_pc;
  assign unused_pc = ^{lk_pc, fb_pc};

  // Sweep state machine: one entry invalidated per cycle, ENTRIES cycles total.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == LAST_IDX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy    <= (state_d == SWEEP);
    end
  end

  // Per-lane lookup against pre-update contents; all lanes are independent.
  always_comb begin
    hit_d   = '0;
    use_d   = '0;
    value_d = '0;
    conf_d  = '0;
    for (int k = 0; k < int'(NUM_LANES); k++) begin
      lk_idx[k] = lk_pc[PC_W*k +: IDX_W];
      lk_tag[k] = lk_pc[PC_W*k + IDX_W +: TAG_W];
      if (state_q == IDLE && lk_valid[k] && v_q[lk_idx[k]] &&
          tag_mem[lk_idx[k]] == lk_tag[k]) begin
        hit_d[k]                    = 1'b1;
        value_d[VAL_W*k +: VAL_W]   = val_mem[lk_idx[k]];
        conf_d[CONF_W*k +: CONF_W]  = conf_mem[lk_idx[k]];
        use_d[k]                    = (conf_mem[lk_idx[k]] >= THRESH);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pred_valid <= '0;
      pred_value <= '0;
      pred_conf  <= '0;
      pred_use   <= '0;
    end else begin
      pred_valid <= hit_d;
      pred_value <= value_d;
      pred_conf  <= conf_d;
      pred_use   <= use_d;
    end
  end

  // Training: a matching hit strengthens confidence, anything else reallocates.
  always_comb begin
    fb_idx   = fb_pc[IDX_W-1:0];
    fb_tag   = fb_pc[IDX_W +: TAG_W];
    fb_hit   = v_q[fb_idx] && (tag_mem[fb_idx] == fb_tag);
    fb_match = fb_hit && (val_mem[fb_idx] == fb_actual);
    train    = fb_valid && (state_q == IDLE);
    conf_new = '0;
    if (fb_match) begin
      conf_new = (conf_mem[fb_idx] == CONF_MAX) ? CONF_MAX
                                                : conf_mem[fb_idx] + CONF_W'(1);
    end
    misp_d   = train && fb_used && !fb_match;
  end

  always_ff @(posedge clk) begin
    if (train) begin
      tag_mem[fb_idx]  <= fb_tag;
      val_mem[fb_idx]  <= fb_actual;
      conf_mem[fb_idx] <= conf_new;
    end
  end

  // Valid bits: sweep clearing and training allocation are mutually exclusive.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      v_q <= '0;
    end else if (state_q == SWEEP) begin
      v_q[ptr_q] <= 1'b0;
    end else if (train) begin
      v_q[fb_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) fb_misp <= 1'b0;
    else        fb_misp <= misp_d;
  end

endmodule
